// File: rtl/fas_pkg.sv
// fas_pkg -- shared types and width helpers for the FAS analysis stage.
//   state_t      : peak analyser group state
//   fw_of/pw_of/aw_of : index, power and accumulator widths
//   RE_LSB/IM_LSB: field positions inside a packed complex bin {re, im}
package fas_pkg;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAST   = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  function automatic int fw_of(int nbins);
    return $clog2(nbins);
  endfunction

  // re^2 + im^2 peaks at 2^(2*DW-1); one spare bit keeps it unsigned.
  function automatic int pw_of(int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int aw_of(int dw, int avg_log2);
    return 2 * dw + 1 + avg_log2;
  endfunction

  // bin_d = {re, im}
  function automatic int re_lsb(int dw);
    return dw;
  endfunction

  localparam int IM_LSB = 0;

endpackage

// File: rtl/fas_peak_analyzer_if.sv
// fas_peak_analyzer_if -- bin stream in, peak report out.
//   bin_valid/bin_d/bin_last : complex FFT bin stream, no backpressure
//   thresh                   : detection threshold, used when a report forms
//   done/freq/peak_pwr/peak_found : report (done pulses, the rest hold)
//   frame_err                : one-cycle pulse on a frame-marker violation
// master = bin source / report sink, slave = analyser.
interface fas_peak_analyzer_if #(
  parameter int NBINS = 16,
  parameter int DW    = 16
) ();
  localparam int FW = fas_pkg::fw_of(NBINS);
  localparam int PW = fas_pkg::pw_of(DW);

  logic              bin_valid;
  logic [2*DW-1:0]   bin_d;
  logic              bin_last;
  logic [PW-1:0]     thresh;
  logic              done;
  logic [FW-1:0]     freq;
  logic [PW-1:0]     peak_pwr;
  logic              peak_found;
  logic              frame_err;

  modport master (
    output bin_valid, bin_d, bin_last, thresh,
    input  done, freq, peak_pwr, peak_found, frame_err
  );

  modport slave (
    input  bin_valid, bin_d, bin_last, thresh,
    output done, freq, peak_pwr, peak_found, frame_err
  );
endinterface

// File: rtl/fas_bin_power.sv
// fas_bin_power -- registered magnitude-squared of one complex sample.
//   clk, rst : clock, synchronous active-high reset
//   en       : load a new result this cycle
//   re, im   : signed DW-bit components
//   pwr      : re*re + im*im, unsigned 2*DW+1 bits, one cycle after en
module fas_bin_power #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic [2*DW:0]        pwr
);
  logic signed [2*DW-1:0] re_sq;
  logic signed [2*DW-1:0] im_sq;

  // Squares are never negative, so they can be zero-extended before the add.
  assign re_sq = re * re;
  assign im_sq = im * im;

  always_ff @(posedge clk) begin
    if (rst)     pwr <= '0;
    else if (en) pwr <= {1'b0, re_sq} + {1'b0, im_sq};
  end
endmodule

// File: rtl/fas_peak_analyzer.sv
// fas_peak_analyzer -- per-bin power, optional 2^AVG_LOG2 frame accumulation,
// and strongest-bin report after the last frame of each group.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fas_peak_analyzer_if.slave (bin stream in, report out)
// Pipeline: stage 0 checks frame markers and steps the FSM; stage 1 holds
// power, previous accumulation and bin index; stage 2 accumulates, tracks
// the running max and forms the report.
module fas_peak_analyzer
  import fas_pkg::*;
#(
  parameter int NBINS    = 16,
  parameter int DW       = 16,
  parameter int AVG_LOG2 = 0
) (
  input logic               clk,
  input logic               rst,
  fas_peak_analyzer_if.slave bus
);
  localparam int FW     = fw_of(NBINS);
  localparam int PW     = pw_of(DW);
  localparam int AW     = aw_of(DW, AVG_LOG2);
  localparam int CW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FRAMES = 1 << AVG_LOG2;

  // With a single frame per group every frame is the group's last one.
  localparam state_t          FILL_ST   = (AVG_LOG2 == 0) ? S_LAST : S_FILL;
  localparam logic [FW-1:0]   IDX_LAST  = FW'(NBINS - 1);
  localparam logic [CW-1:0]   FCNT_LAST = CW'(FRAMES - 1);

  // ---------------- stage 0: marker check + FSM ----------------
  state_t          state, state_nx;
  logic [FW-1:0]   idx, idx_nx;
  logic [CW-1:0]   fcnt, fcnt_nx;
  logic            accept, err_early, err_miss;

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    fcnt_nx   = fcnt;
    accept    = 1'b0;
    err_early = 1'b0;
    err_miss  = 1'b0;
    if (bus.bin_valid) begin
      if (state == S_RESYNC) begin
        // The marker bin closes the garbage frame; the next bin is index 0.
        if (bus.bin_last) begin
          state_nx = FILL_ST;
          idx_nx   = '0;
          fcnt_nx  = '0;
        end
      end else if (bus.bin_last && idx != IDX_LAST) begin
        // Early marker: treat it as the frame boundary and restart the group.
        err_early = 1'b1;
        state_nx  = FILL_ST;
        idx_nx    = '0;
        fcnt_nx   = '0;
      end else if (!bus.bin_last && idx == IDX_LAST) begin
        err_miss = 1'b1;
        state_nx = S_RESYNC;
        idx_nx   = '0;
        fcnt_nx  = '0;
      end else begin
        accept = 1'b1;
        idx_nx = idx + 1'b1;
        if (bus.bin_last) begin
          if (state == S_LAST) begin
            fcnt_nx  = '0;
            state_nx = FILL_ST;
          end else begin
            fcnt_nx = fcnt + 1'b1;
            if (fcnt + 1'b1 == FCNT_LAST) state_nx = S_LAST;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL_ST;
      idx   <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // ---------------- stage 1 ----------------
  // The erroring bin never enters the pipe. An older bin still in stage 1
  // belongs either to a completed frame (must report) or is a non-final bin
  // whose acc/max effects are masked by fcnt==0 and the bin-0 max restart,
  // so nothing already in flight needs to be killed.
  logic [AW-1:0] acc_mem [NBINS];
  logic [PW-1:0] s1_pwr;
  logic [AW-1:0] s1_acc;
  logic [FW-1:0] s1_idx;
  logic          s1_vld, s1_last, s1_grp_last;

  fas_bin_power #(.DW(DW)) u_pwr (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .re  (bus.bin_d[re_lsb(DW) +: DW]),
    .im  (bus.bin_d[IM_LSB +: DW]),
    .pwr (s1_pwr)
  );

  always_ff @(posedge clk) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= accept;
  end

  // First frame of a group starts from zero, so acc_mem needs no clearing.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_acc      <= (fcnt == '0) ? '0 : acc_mem[idx];
      s1_idx      <= idx;
      s1_last     <= bus.bin_last;
      s1_grp_last <= (state == S_LAST);
    end
  end

  // ---------------- stage 2 ----------------
  logic [AW-1:0] sum, max_sum, base_max, new_max;
  logic [FW-1:0] max_idx, base_idx, new_idx;
  logic [PW-1:0] pk;

  always_comb begin
    sum      = s1_acc + AW'(s1_pwr);
    base_max = (s1_idx == '0) ? '0 : max_sum;
    base_idx = (s1_idx == '0) ? '0 : max_idx;
    // Strict compare: ties keep the lower index.
    if (sum > base_max) begin
      new_max = sum;
      new_idx = s1_idx;
    end else begin
      new_max = base_max;
      new_idx = base_idx;
    end
    pk = PW'(new_max >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (s1_vld) acc_mem[s1_idx] <= sum;
  end

  logic          done_q, found_q, ferr_q;
  logic [FW-1:0] freq_q;
  logic [PW-1:0] pwr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_sum <= '0;
      max_idx <= '0;
      done_q  <= 1'b0;
      freq_q  <= '0;
      pwr_q   <= '0;
      found_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= err_early | err_miss;
      if (s1_vld && s1_grp_last) begin
        max_sum <= new_max;
        max_idx <= new_idx;
        if (s1_last) begin
          done_q  <= 1'b1;
          freq_q  <= new_idx;
          pwr_q   <= pk;
          found_q <= (pk >= bus.thresh);
        end
      end
    end
  end

  assign bus.done       = done_q;
  assign bus.freq       = freq_q;
  assign bus.peak_pwr   = pwr_q;
  assign bus.peak_found = found_q;
  assign bus.frame_err  = ferr_q;
endmodule
